spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master.sv | 163 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// SPI mode-0 configuration master: shifts one 16-bit {addr, data} frame per accepted command
// and captures the 16 bits returned on poci. Every output comes straight from a flop.
module spi_cfg_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_addr_i,
    input  logic [11:0] cmd_data_i,
    output logic        sclk_o,
    output logic        pico_o,
    output logic        cs_o,
    input  logic        poci_i,
    output logic [15:0] rx_data_o,
    output logic        done_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {StIdle, StSetup, StShiftHi, StShiftLo, StGap} state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    // The IDLE cycle is the last cycle of the CS-high gap, so GAP itself runs one cycle short
    // and is skipped entirely when a single gap cycle is requested.
    localparam bit         HasGap  = (GAP_CYCLES > 1);
    localparam logic [7:0] GapLast = HasGap ? 8'(GAP_CYCLES - 2) : 8'd0;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] rx_sh_q, rx_sh_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        pico_q, pico_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        pico_d    = pico_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i && ready_q) begin
                    frame_d   = {cmd_addr_i, cmd_data_i};
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    pico_d    = cmd_addr_i[3];
                    cnt_d     = 8'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    cnt_d                      = 8'd0;
                    sclk_d                     = 1'b1;
                    rx_sh_d[4'd15 - bit_cnt_q] = poci_i;
                    state_d                    = StShiftHi;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShiftHi: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = 8'd0;
                    sclk_d  = 1'b0;
                    state_d = StShiftLo;
                    // After the last bit pico simply keeps frame[0].
                    if (bit_cnt_q != 4'd15) begin
                        pico_d = frame_q[4'd14 - bit_cnt_q];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShiftLo: begin
                if (cnt_q == DivLast) begin
                    cnt_d     = 8'd0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        cs_d      = 1'b1;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                        state_d   = HasGap ? StGap : StIdle;
                    end else begin
                        sclk_d                     = 1'b1;
                        rx_sh_d[4'd14 - bit_cnt_q] = poci_i;
                        state_d                    = StShiftHi;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 16'd0;
            rx_sh_q   <= 16'd0;
            rx_data_q <= 16'd0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            pico_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            pico_q    <= pico_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign sclk_o      = sclk_q;
    assign pico_o      = pico_q;
    assign cs_o        = cs_q;
    assign rx_data_o   = rx_data_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: one instance at CLK_DIV=4/GAP=8, one at CLK_DIV=2/GAP=1,
// a bus monitor that decodes frames and an optional mode-0 slave on poci.
module tb_spi_cfg_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic [3:0]  addr    = 4'd0;
    logic [11:0] data    = 12'd0;
    logic        poci    = 1'b1;

    logic        ready_a, sclk_a, pico_a, cs_a, done_a, busy_a;
    logic        ready_b, sclk_b, pico_b, cs_b, done_b, busy_b;
    logic [15:0] rx_a, rx_b;

    spi_cfg_master #(.CLK_DIV(4), .GAP_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid_i(valid_a), .cmd_ready_o(ready_a),
        .cmd_addr_i(addr), .cmd_data_i(data), .sclk_o(sclk_a), .pico_o(pico_a),
        .cs_o(cs_a), .poci_i(poci), .rx_data_o(rx_a), .done_o(done_a), .busy_o(busy_a)
    );

    spi_cfg_master #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid_i(valid_b), .cmd_ready_o(ready_b),
        .cmd_addr_i(addr), .cmd_data_i(data), .sclk_o(sclk_b), .pico_o(pico_b),
        .cs_o(cs_b), .poci_i(poci), .rx_data_o(rx_b), .done_o(done_b), .busy_o(busy_b)
    );

    logic use_b = 1'b0;
    wire        m_cs    = use_b ? cs_b : cs_a;
    wire        m_sclk  = use_b ? sclk_b : sclk_a;
    wire        m_pico  = use_b ? pico_b : pico_a;
    wire        m_done  = use_b ? done_b : done_a;
    wire        m_ready = use_b ? ready_b : ready_a;
    wire [15:0] m_rx    = use_b ? rx_b : rx_a;

    int checks = 0;
    int passes = 0;

    // Monitor / slave state
    int          frames      = 0;
    int          done_cnt    = 0;
    int          rises_cur   = 0;
    int          cs_low_run  = 0;
    int          cs_high_run = 0;
    int          since_rise  = 0;
    int          last_period = 0;
    logic [15:0] tx_sh       = 16'd0;
    logic [15:0] rx_at_done  = 16'd0;
    logic [15:0] tx_log [32];
    int          cs_low_log [32];
    int          rises_log [32];
    int          gap_log [32];
    logic        prev_cs     = 1'b1;
    logic        prev_sclk   = 1'b0;
    bit          slave_en    = 1'b0;
    logic [15:0] slave_word  = 16'd0;
    int          slave_idx   = 0;
    logic        poci_const  = 1'b1;

    always begin
        @(posedge clk);
        #1;
        if (m_done === 1'b1) begin
            done_cnt++;
            rx_at_done = m_rx;
        end
        if (m_cs === 1'b0 && prev_cs === 1'b1) begin
            if (frames < 32) gap_log[frames] = cs_high_run;
            cs_high_run = 0;
            rises_cur   = 0;
            tx_sh       = 16'd0;
            since_rise  = 0;
            slave_idx   = 14;
            if (slave_en) poci = slave_word[15];
        end
        if (m_cs === 1'b1 && prev_cs === 1'b0) begin
            if (frames < 32) begin
                tx_log[frames]     = tx_sh;
                cs_low_log[frames] = cs_low_run;
                rises_log[frames]  = rises_cur;
            end
            frames++;
            cs_low_run = 0;
        end
        if (m_cs === 1'b0) cs_low_run++;
        else cs_high_run++;
        since_rise++;
        if (m_cs === 1'b0 && m_sclk === 1'b1 && prev_sclk === 1'b0) begin
            tx_sh = {tx_sh[14:0], m_pico};
            if (rises_cur > 0) last_period = since_rise;
            since_rise = 0;
            rises_cur++;
        end
        // Mode-0 slave: next bit goes out on each falling SCLK edge.
        if (slave_en && m_cs === 1'b0 && m_sclk === 1'b0 && prev_sclk === 1'b1) begin
            if (slave_idx >= 0) begin
                poci = slave_word[slave_idx];
                slave_idx--;
            end
        end
        if (!slave_en) poci = poci_const;
        prev_cs   = m_cs;
        prev_sclk = m_sclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [3:0] a, input logic [11:0] d, input bit keep,
                        output bit ok);
        int n;
        n    = 0;
        addr = a;
        data = d;
        if (use_b) valid_b = 1'b1;
        else valid_a = 1'b1;
        while (m_ready !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        ok = (m_ready === 1'b1);
        step();
        if (!keep) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, output bit ok);
        int n;
        n = 0;
        while (frames < target && n < 2000) begin
            step();
            n++;
        end
        ok = (frames >= target);
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (m_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        ok = (m_ready === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] obs [9];
        logic [31:0] exp [9];
        string       nm [9];
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (3) step();
        obs[0] = 32'(cs_a);   exp[0] = 32'd1; nm[0] = "reset_cs";
        obs[1] = 32'(sclk_a); exp[1] = 32'd0; nm[1] = "reset_sclk";
        obs[2] = 32'(pico_a); exp[2] = 32'd0; nm[2] = "reset_pico";
        obs[3] = 32'(done_a); exp[3] = 32'd0; nm[3] = "reset_done";
        obs[4] = 32'(busy_a); exp[4] = 32'd0; nm[4] = "reset_busy";
        obs[5] = 32'(rx_a);   exp[5] = 32'd0; nm[5] = "reset_rx";
        obs[6] = 32'(cs_b);   exp[6] = 32'd1; nm[6] = "reset_cs_b";
        rst = 1'b0;
        step();
        obs[7] = 32'(ready_a); exp[7] = 32'd1; nm[7] = "post_reset_ready";
        obs[8] = 32'(busy_a);  exp[8] = 32'd0; nm[8] = "post_reset_busy";
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_single();
        logic [31:0] obs [14];
        logic [31:0] exp [14];
        string       nm [14];
        int f0, d0;
        bit ok_s, ok_w, ok_i;
        poci_const = 1'b1;
        slave_en   = 1'b0;
        f0 = frames;
        d0 = done_cnt;
        send(4'h3, 12'hA5C, 1'b0, ok_s);
        obs[0] = 32'(ready_a); exp[0] = 32'd0; nm[0] = "single_ready_after_accept";
        obs[1] = 32'(busy_a);  exp[1] = 32'd1; nm[1] = "single_busy_after_accept";
        obs[2] = 32'(cs_a);    exp[2] = 32'd0; nm[2] = "single_cs_after_accept";
        obs[3] = 32'(sclk_a);  exp[3] = 32'd0; nm[3] = "single_sclk_after_accept";
        obs[4] = 32'(pico_a);  exp[4] = 32'd0; nm[4] = "single_pico_msb";
        wait_frames(f0 + 1, ok_w);
        obs[5]  = 32'(tx_log[f0]);     exp[5]  = 32'h3A5C; nm[5]  = "single_tx_word";
        obs[6]  = 32'(cs_low_log[f0]); exp[6]  = 32'd132;  nm[6]  = "single_cs_low_cycles";
        obs[7]  = 32'(rises_log[f0]);  exp[7]  = 32'd16;   nm[7]  = "single_sclk_rises";
        obs[8]  = 32'(rx_at_done);     exp[8]  = 32'hFFFF; nm[8]  = "single_rx_at_done";
        obs[9]  = 32'(last_period);    exp[9]  = 32'd8;    nm[9]  = "single_sclk_period";
        obs[10] = {30'd0, ok_s, ok_w}; exp[10] = 32'd3;    nm[10] = "single_no_timeout";
        wait_idle(ok_i);
        repeat (5) step();
        obs[11] = 32'(done_cnt - d0);  exp[11] = 32'd1;    nm[11] = "single_done_pulses";
        obs[12] = 32'(rx_a);           exp[12] = 32'hFFFF; nm[12] = "single_rx_stable";
        obs[13] = 32'(ok_i);           exp[13] = 32'd1;    nm[13] = "single_idle_timeout";
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_loopback();
        logic [31:0] obs [6];
        logic [31:0] exp [6];
        string       nm [6];
        int f0, d0;
        bit ok_s, ok_w, ok_i;
        slave_word = 16'h1234;
        slave_en   = 1'b1;
        f0 = frames;
        d0 = done_cnt;
        send(4'h5, 12'h0F1, 1'b0, ok_s);
        wait_frames(f0 + 1, ok_w);
        obs[0] = 32'(rx_at_done);      exp[0] = 32'h1234; nm[0] = "loop_rx_at_done";
        obs[1] = 32'(rx_a);            exp[1] = 32'h1234; nm[1] = "loop_rx_data";
        obs[2] = 32'(tx_log[f0]);      exp[2] = 32'h50F1; nm[2] = "loop_tx_word";
        obs[3] = 32'(pico_a);          exp[3] = 32'd1;    nm[3] = "loop_pico_holds_lsb";
        obs[4] = 32'(done_cnt - d0);   exp[4] = 32'd1;    nm[4] = "loop_done_pulses";
        wait_idle(ok_i);
        obs[5] = {29'd0, ok_s, ok_w, ok_i}; exp[5] = 32'd7; nm[5] = "loop_no_timeout";
        slave_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs [5];
        logic [31:0] exp [5];
        string       nm [5];
        int f0;
        bit ok1, ok2, ok_w, ok_i;
        f0 = frames;
        send(4'hC, 12'h123, 1'b1, ok1);
        send(4'h6, 12'hBCD, 1'b0, ok2);
        wait_frames(f0 + 2, ok_w);
        obs[0] = 32'(tx_log[f0]);         exp[0] = 32'hC123; nm[0] = "b2b_first_word";
        obs[1] = 32'(tx_log[f0 + 1]);     exp[1] = 32'h6BCD; nm[1] = "b2b_second_word";
        obs[2] = 32'(gap_log[f0 + 1]);    exp[2] = 32'd8;    nm[2] = "b2b_cs_high_gap";
        obs[3] = 32'(cs_low_log[f0 + 1]); exp[3] = 32'd132;  nm[3] = "b2b_second_cs_low";
        wait_idle(ok_i);
        obs[4] = {28'd0, ok1, ok2, ok_w, ok_i}; exp[4] = 32'hF; nm[4] = "b2b_no_timeout";
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_stability();
        logic [31:0] obs [4];
        logic [31:0] exp [4];
        string       nm [4];
        int f0, bad, n;
        bit ok_s, ok_i;
        f0  = frames;
        bad = 0;
        n   = 0;
        send(4'h9, 12'h3C6, 1'b1, ok_s);
        while (frames == f0 && n < 1000) begin
            addr = ~addr;
            data = ~data;
            step();
            if (ready_a !== 1'b0 && frames == f0) bad++;
            n++;
        end
        valid_a = 1'b0;
        obs[0] = 32'(tx_log[f0]); exp[0] = 32'h93C6; nm[0] = "stable_tx_word";
        obs[1] = 32'(bad);        exp[1] = 32'd0;    nm[1] = "stable_ready_low_in_frame";
        wait_idle(ok_i);
        repeat (3) step();
        obs[2] = 32'(cs_a);       exp[2] = 32'd1;    nm[2] = "stable_no_extra_frame";
        obs[3] = {29'd0, ok_s, ok_i, (frames > f0)}; exp[3] = 32'd7; nm[3] = "stable_no_timeout";
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] obs [11];
        logic [31:0] exp [11];
        string       nm [11];
        int d0, f1, n;
        bit ok_s, ok_s2, ok_w;
        n = 0;
        send(4'hA, 12'h5F0, 1'b0, ok_s);
        while (!(rises_cur == 8 && cs_a === 1'b0) && n < 1000) begin
            step();
            n++;
        end
        d0  = done_cnt;
        rst = 1'b1;
        step();
        obs[0] = 32'(cs_a);   exp[0] = 32'd1; nm[0] = "abort_cs";
        obs[1] = 32'(sclk_a); exp[1] = 32'd0; nm[1] = "abort_sclk";
        obs[2] = 32'(busy_a); exp[2] = 32'd0; nm[2] = "abort_busy";
        obs[3] = 32'(rx_a);   exp[3] = 32'd0; nm[3] = "abort_rx";
        obs[4] = 32'(done_a); exp[4] = 32'd0; nm[4] = "abort_done";
        rst = 1'b0;
        step();
        obs[5] = 32'(ready_a); exp[5] = 32'd1; nm[5] = "abort_ready_after_rst";
        repeat (20) step();
        obs[6] = 32'(done_cnt - d0); exp[6] = 32'd0; nm[6] = "abort_no_done";
        f1 = frames;
        send(4'h1, 12'h234, 1'b0, ok_s2);
        wait_frames(f1 + 1, ok_w);
        obs[7] = 32'(tx_log[f1]);     exp[7] = 32'h1234; nm[7] = "abort_next_word";
        obs[8] = 32'(rises_log[f1]);  exp[8] = 32'd16;   nm[8] = "abort_next_rises";
        obs[9] = 32'(cs_low_log[f1]); exp[9] = 32'd132;  nm[9] = "abort_next_cs_low";
        obs[10] = {28'd0, ok_s, (n < 1000), ok_s2, ok_w}; exp[10] = 32'hF;
        nm[10] = "abort_no_timeout";
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    task automatic test_min_div();
        logic [31:0] obs [8];
        logic [31:0] exp [8];
        string       nm [8];
        int f0;
        bit ok1, ok2, ok_w, ok_i;
        bit ok_a;
        wait_idle(ok_a);
        use_b = 1'b1;
        repeat (2) step();
        f0 = frames;
        send(4'hF, 12'h00F, 1'b1, ok1);
        send(4'h0, 12'hFF0, 1'b0, ok2);
        wait_frames(f0 + 2, ok_w);
        obs[0] = 32'(tx_log[f0]);         exp[0] = 32'hF00F; nm[0] = "min_first_word";
        obs[1] = 32'(tx_log[f0 + 1]);     exp[1] = 32'h0FF0; nm[1] = "min_second_word";
        obs[2] = 32'(cs_low_log[f0]);     exp[2] = 32'd66;   nm[2] = "min_cs_low_first";
        obs[3] = 32'(cs_low_log[f0 + 1]); exp[3] = 32'd66;   nm[3] = "min_cs_low_second";
        obs[4] = 32'(gap_log[f0 + 1]);    exp[4] = 32'd1;    nm[4] = "min_cs_high_gap";
        obs[5] = 32'(last_period);        exp[5] = 32'd4;    nm[5] = "min_sclk_period";
        obs[6] = 32'(rises_log[f0 + 1]);  exp[6] = 32'd16;   nm[6] = "min_sclk_rises";
        wait_idle(ok_i);
        obs[7] = {27'd0, ok_a, ok1, ok2, ok_w, ok_i}; exp[7] = 32'h1F; nm[7] = "min_no_timeout";
        use_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== exp[i])
                $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], exp[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_stability();
        test_reset_mid_frame();
        test_min_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
